pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
Pipeline sequencing controller for the 5-stage core. Drives the load enables of the PC, IF/ID, ID/EX and EX/MEM registers and the IF/ID flush. Generates the ID/EX bubble select. Handles:
- post-reset pipeline fill
- load-use stalls
- taken-branch flushes
- multi-cycle data-memory waits with timeout
- halt requests

Parameters:
INIT_CYCLES, 2, cycles after reset with fetch held and bubbles injected (>=1)
MEM_TIMEOUT, 16, max consecutive mem_busy cycles in MEM_WAIT before fault (>=2)
CNT_W, 16, width of the statistics counters

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
id_rs  in  5  rs field of instruction in ID
id_rt  in  5  rt field of instruction in ID
id_uses_rs  in  1  ID instruction reads rs
id_uses_rt  in  1  ID instruction reads rt
ex_load  in  1  instruction in EX is a load
ex_dest  in  5  destination register of EX instruction
branch_taken  in  1  ID resolved a taken branch/jump this cycle
mem_busy  in  1  data memory not ready this cycle
halt_req  in  1  halt request from decode
pc_le  out  1  PC load enable
ifid_le  out  1  IF/ID load enable
ifid_flush  out  1  IF/ID loads zero (NOP) instead of fetched word
idex_le  out  1  ID/EX load enable
idex_bubble  out  1  ID/EX control fields forced to zero
exmem_le  out  1  EX/MEM load enable
halted  out  1  FSM in HALT
err_timeout  out  1  sticky memory-timeout fault
stall_cnt  out  CNT_W  load-use + memory stall cycles (optional feature)
flush_cnt  out  CNT_W  branch flushes (optional feature)

Behaviour:
- States: INIT, RUN, MEM_WAIT, HALT. State register and counters reset asynchronously.
- Outputs are combinational, decoded from the current state and current-cycle inputs. Stalls therefore act in the same cycle the condition appears.
- Reset values:
  - State INIT, init_cnt=0, wait_cnt=0.
  - err_timeout=0, stall_cnt=0, flush_cnt=0.
  - Outputs while reset is asserted: pc_le=0, ifid_le=0, idex_le=0, exmem_le=0, ifid_flush=1, idex_bubble=1, halted=0.
- Load-use hazard (luh) condition: ex_load & ex_dest!=0 & ((id_uses_rs & id_rs==ex_dest) | (id_uses_rt & id_rt==ex_dest)).
- INIT:
  - Outputs: pc_le=0, ifid_le=1, ifid_flush=1, idex_le=1, idex_bubble=1, exmem_le=1.
  - init_cnt increments each cycle.
  - When init_cnt==INIT_CYCLES-1, next state is RUN. INIT therefore lasts exactly INIT_CYCLES cycles.
  - All inputs are ignored in INIT.
- RUN: evaluated with priority halt_req > mem_busy > luh > branch_taken.
  - halt_req: all four enables=0; next state HALT.
  - mem_busy: all four enables=0, flush=0, bubble=0 (full freeze); next state MEM_WAIT; wait_cnt=1.
  - luh: pc_le=0, ifid_le=0, idex_le=1, idex_bubble=1, exmem_le=1. Stays in RUN. branch_taken is suppressed this cycle; the branch re-resolves next cycle.
  - branch_taken: pc_le=1, ifid_le=1, ifid_flush=1, idex_le=1, exmem_le=1.
  - None of the above: all four enables=1, flush=0, bubble=0.
- MEM_WAIT:
  - mem_busy=1:
    - Full freeze.
    - If wait_cnt==MEM_TIMEOUT: next state HALT, err_timeout<=1.
    - Otherwise wait_cnt increments.
  - mem_busy=0: outputs decoded exactly as RUN (same priority, including halt_req); next state follows the RUN rules. wait_cnt<=0.
- HALT: all enables=0, halted=1. Exit only by reset. err_timeout holds.
- Every output in every state is driven: no latches and no X.

Optional Feature:
STALL_STATS_EN:
- Defined:
  - stall_cnt increments on every cycle where RUN/MEM_WAIT takes the mem_busy or luh branch.
  - flush_cnt increments on every cycle where the branch_taken flush is taken.
  - Both saturate at all-ones and reset to 0.
- Undefined: the ports exist, are tied to 0, and no counter flops are synthesized.

Test Plan:
- Reset released, INIT_CYCLES=2 -> exactly 2 cycles of pc_le=0, ifid_flush=1, idex_bubble=1, then pc_le=ifid_le=1 on cycle 3.
- RUN, ex_load=1, ex_dest=5, id_rs=5, id_uses_rs=1, branch_taken=1 -> same cycle pc_le=0, ifid_le=0, idex_bubble=1, ifid_flush=0. Next cycle with ex_load=0 and branch_taken=1 -> ifid_flush=1, pc_le=1.
- ex_load=1, ex_dest=0, id_rs=0 -> no stall.
- mem_busy high for 3 cycles -> 3 freeze cycles (all enables=0). Cycle 4 with mem_busy=0 -> all enables=1; err_timeout stays 0.
- mem_busy held 20 cycles, MEM_TIMEOUT=16 -> HALT after the 17th busy cycle, err_timeout=1, halted=1. mem_busy dropping afterwards has no effect. reset pulse -> INIT, err_timeout=0.
- STALL_STATS_EN defined: 2 luh cycles + 3 mem_busy cycles + 1 flush -> stall_cnt=5, flush_cnt=1. Undefined: both read 0.

Source files
------------

// File: rtl/pipe_hazard_ctrl_if.sv
// ============================================================================
// pipe_hazard_ctrl_if : pipeline-control bundle between the hazard controller
//                       and the 5-stage datapath.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_uses_rs;
  logic             id_uses_rt;
  logic             ex_load;
  logic [4:0]       ex_dest;
  logic             branch_taken;
  logic             mem_busy;
  logic             halt_req;

  logic             pc_le;
  logic             ifid_le;
  logic             ifid_flush;
  logic             idex_le;
  logic             idex_bubble;
  logic             exmem_le;
  logic             halted;
  logic             err_timeout;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output id_rs, id_rt, id_uses_rs, id_uses_rt, ex_load, ex_dest,
           branch_taken, mem_busy, halt_req,
    input  pc_le, ifid_le, ifid_flush, idex_le, idex_bubble, exmem_le,
           halted, err_timeout, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rs, id_uses_rt, ex_load, ex_dest,
           branch_taken, mem_busy, halt_req,
    output pc_le, ifid_le, ifid_flush, idex_le, idex_bubble, exmem_le,
           halted, err_timeout, stall_cnt, flush_cnt
  );
endinterface

`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
// ============================================================================
// pipe_hazard_ctrl : stall / flush / bubble sequencing for the 5-stage core.
// Optional statistics counters enabled by macro STALL_STATS_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module pipe_hazard_ctrl #(
  parameter int INIT_CYCLES = 2,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  wire logic         clk,
  input  wire logic         reset,
  pipe_hazard_ctrl_if.slave bus
);

  localparam int INIT_W = $clog2(INIT_CYCLES) + 1;
  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {
    INIT     = 2'd0,
    RUN      = 2'd1,
    MEM_WAIT = 2'd2,
    HALT     = 2'd3
  } state_t;

  state_t            state;
  logic [INIT_W-1:0] init_cnt;
  logic [WAIT_W-1:0] wait_cnt;
  logic              err_timeout_q;

  logic active;
  logic luh;
  logic halt_take;
  logic busy_take;
  logic luh_take;
  logic br_take;

  assign luh = bus.ex_load && (bus.ex_dest != 5'd0) &&
               ((bus.id_uses_rs && (bus.id_rs == bus.ex_dest)) ||
                (bus.id_uses_rt && (bus.id_rt == bus.ex_dest)));

  // A pending memory wait outranks halt_req; in RUN halt_req outranks everything.
  assign active    = (state == RUN) || (state == MEM_WAIT);
  assign halt_take = active && bus.halt_req && !((state == MEM_WAIT) && bus.mem_busy);
  assign busy_take = active && bus.mem_busy && !halt_take;
  assign luh_take  = active && !halt_take && !busy_take && luh;
  assign br_take   = active && !halt_take && !busy_take && !luh && bus.branch_taken;

  always_comb begin
    bus.pc_le       = 1'b1;
    bus.ifid_le     = 1'b1;
    bus.ifid_flush  = 1'b0;
    bus.idex_le     = 1'b1;
    bus.idex_bubble = 1'b0;
    bus.exmem_le    = 1'b1;
    bus.halted      = 1'b0;
    if (reset) begin
      bus.pc_le       = 1'b0;
      bus.ifid_le     = 1'b0;
      bus.ifid_flush  = 1'b1;
      bus.idex_le     = 1'b0;
      bus.idex_bubble = 1'b1;
      bus.exmem_le    = 1'b0;
    end else if (state == INIT) begin
      bus.pc_le       = 1'b0;
      bus.ifid_flush  = 1'b1;
      bus.idex_bubble = 1'b1;
    end else if (state == HALT) begin
      bus.pc_le    = 1'b0;
      bus.ifid_le  = 1'b0;
      bus.idex_le  = 1'b0;
      bus.exmem_le = 1'b0;
      bus.halted   = 1'b1;
    end else if (halt_take || busy_take) begin
      bus.pc_le    = 1'b0;
      bus.ifid_le  = 1'b0;
      bus.idex_le  = 1'b0;
      bus.exmem_le = 1'b0;
    end else if (luh_take) begin
      bus.pc_le       = 1'b0;
      bus.ifid_le     = 1'b0;
      bus.idex_bubble = 1'b1;
    end else if (br_take) begin
      bus.ifid_flush = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= INIT;
      init_cnt      <= '0;
      wait_cnt      <= '0;
      err_timeout_q <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          init_cnt <= init_cnt + INIT_W'(1);
          if (init_cnt == INIT_W'(INIT_CYCLES - 1))
            state <= RUN;
        end
        RUN, MEM_WAIT: begin
          if (busy_take) begin
            if (state == MEM_WAIT) begin
              if (wait_cnt == WAIT_W'(MEM_TIMEOUT)) begin
                state         <= HALT;
                err_timeout_q <= 1'b1;
              end else begin
                wait_cnt <= wait_cnt + WAIT_W'(1);
              end
            end else begin
              state    <= MEM_WAIT;
              wait_cnt <= WAIT_W'(1);
            end
          end else begin
            wait_cnt <= '0;
            state    <= halt_take ? HALT : RUN;
          end
        end
        default: state <= HALT;
      endcase
    end
  end

  assign bus.err_timeout = err_timeout_q;

`ifdef STALL_STATS_EN
  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] flush_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if ((busy_take || luh_take) && (stall_q != {CNT_W{1'b1}}))
        stall_q <= stall_q + CNT_W'(1);
      if (br_take && (flush_q != {CNT_W{1'b1}}))
        flush_q <= flush_q + CNT_W'(1);
    end
  end

  assign bus.stall_cnt = stall_q;
  assign bus.flush_cnt = flush_q;
`else
  assign bus.stall_cnt = {CNT_W{1'b0}};
  assign bus.flush_cnt = {CNT_W{1'b0}};
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
// ============================================================================
// tb_pipe_hazard_ctrl : scoreboard bench with a behavioural pipeline model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_pipe_hazard_ctrl;

  localparam int INIT_CYCLES = 2;
  localparam int MEM_TIMEOUT = 16;
  localparam int CNT_W       = 16;
  localparam int CNT_MAX     = (1 << CNT_W) - 1;

  logic clk;
  logic reset;

  pipe_hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

  pipe_hazard_ctrl #(
    .INIT_CYCLES(INIT_CYCLES),
    .MEM_TIMEOUT(MEM_TIMEOUT),
    .CNT_W      (CNT_W)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {pc_le, ifid_le, ifid_flush, idex_le, idex_bubble, exmem_le, halted}
  typedef struct {
    int         cyc;
    logic [6:0] val;
    logic [6:0] mask;
    logic       err;
    int         stall;
    int         flush;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  bit   done   = 0;

  // Model: remaining fill cycles, length of the current busy run, halt flag.
  int m_init_left;
  int m_busy_run;
  bit m_halted;
  bit m_err;
  int m_stall;
  int m_flush;

  task automatic drive(input bit r, input logic [4:0] rs, input logic [4:0] rt,
                       input bit urs, input bit urt, input bit eld,
                       input logic [4:0] ed, input bit br, input bit mb,
                       input bit hr);
    exp_t e;
    bit   hz;
    @(negedge clk);
    reset            = r;
    bus.id_rs        = rs;
    bus.id_rt        = rt;
    bus.id_uses_rs   = urs;
    bus.id_uses_rt   = urt;
    bus.ex_load      = eld;
    bus.ex_dest      = ed;
    bus.branch_taken = br;
    bus.mem_busy     = mb;
    bus.halt_req     = hr;
    cyc++;
    hz = eld && (ed != 0) && ((urs && rs == ed) || (urt && rt == ed));
    e.cyc  = cyc;
    e.mask = 7'b1111111;
    if (r) begin
      m_init_left = INIT_CYCLES;
      m_busy_run  = 0;
      m_halted    = 0;
      m_err       = 0;
      m_stall     = 0;
      m_flush     = 0;
    end
    e.err   = m_err;
`ifdef STALL_STATS_EN
    e.stall = m_stall;
    e.flush = m_flush;
`else
    e.stall = 0;
    e.flush = 0;
`endif
    if (r) begin
      e.val = 7'b0010100;
    end else if (m_halted) begin
      e.val  = 7'b0000001;
      e.mask = 7'b1101011;
    end else if (m_init_left > 0) begin
      e.val = 7'b0111110;
      m_init_left--;
    end else if (m_busy_run > 0 && mb) begin
      e.val = 7'b0000000;
      m_busy_run++;
      m_stall = (m_stall < CNT_MAX) ? m_stall + 1 : m_stall;
      if (m_busy_run > MEM_TIMEOUT) begin
        m_halted = 1;
        m_err    = 1;
      end
    end else begin
      m_busy_run = 0;
      if (hr) begin
        e.val    = 7'b0000000;
        e.mask   = 7'b1101011;
        m_halted = 1;
      end else if (mb) begin
        e.val      = 7'b0000000;
        m_busy_run = 1;
        m_stall    = (m_stall < CNT_MAX) ? m_stall + 1 : m_stall;
      end else if (hz) begin
        e.val   = 7'b0001110;
        m_stall = (m_stall < CNT_MAX) ? m_stall + 1 : m_stall;
      end else if (br) begin
        e.val   = 7'b1111010;
        e.mask  = 7'b1111011;
        m_flush = (m_flush < CNT_MAX) ? m_flush + 1 : m_flush;
      end else begin
        e.val = 7'b1101010;
      end
    end
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic rand_cycle();
    drive(0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          $urandom_range(0, 99) < 40, 5'($urandom_range(0, 3)),
          $urandom_range(0, 99) < 25, $urandom_range(0, 99) < 20,
          $urandom_range(0, 199) < 2);
  endtask

  always @(negedge clk) begin
    #2;
    while (exp_q.size() > 0) begin
      exp_t       e;
      logic [6:0] got;
      e   = exp_q.pop_front();
      got = {bus.pc_le, bus.ifid_le, bus.ifid_flush, bus.idex_le,
             bus.idex_bubble, bus.exmem_le, bus.halted};
      checks++;
      if ((got & e.mask) !== (e.val & e.mask)) begin
        errors++;
        $display("FAIL outputs cyc %0d: got %b want %b (mask %b)",
                 e.cyc, got, e.val, e.mask);
      end
      checks++;
      if (bus.err_timeout !== e.err) begin
        errors++;
        $display("FAIL err_timeout cyc %0d: got %b want %b", e.cyc, bus.err_timeout, e.err);
      end
      checks++;
      if (bus.stall_cnt !== CNT_W'(e.stall)) begin
        errors++;
        $display("FAIL stall_cnt cyc %0d: got %0d want %0d", e.cyc, bus.stall_cnt, e.stall);
      end
      checks++;
      if (bus.flush_cnt !== CNT_W'(e.flush)) begin
        errors++;
        $display("FAIL flush_cnt cyc %0d: got %0d want %0d", e.cyc, bus.flush_cnt, e.flush);
      end
    end
  end

  initial begin
    reset = 1'b1;
    bus.id_rs = 0; bus.id_rt = 0; bus.id_uses_rs = 0; bus.id_uses_rt = 0;
    bus.ex_load = 0; bus.ex_dest = 0; bus.branch_taken = 0;
    bus.mem_busy = 0; bus.halt_req = 0;

    for (int i = 0; i < 3; i++) drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // Fill cycles ignore hazards, busy and halt.
    drive(0, 5, 5, 1, 1, 1, 5, 1, 1, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    idle(1);
    // Load-use with competing branch, then branch re-resolves.
    drive(0, 5, 0, 1, 0, 1, 5, 1, 0, 0);
    drive(0, 5, 0, 1, 0, 0, 5, 1, 0, 0);
    // rt-side hazard, then r0 destination never stalls.
    drive(0, 0, 7, 0, 1, 1, 7, 0, 0, 0);
    drive(0, 0, 0, 1, 1, 1, 0, 0, 0, 0);
    // Three-cycle memory wait.
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    idle(2);
    // Halt request is ignored while memory is still busy, honoured after.
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle(3);
    // Timeout: 20 busy cycles, then mem_busy drops while halted.
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(INIT_CYCLES + 1);
    for (int i = 0; i < 20; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    idle(3);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(INIT_CYCLES + 2);
    // Exactly MEM_TIMEOUT busy cycles must not fault.
    for (int i = 0; i < MEM_TIMEOUT; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    idle(2);

    for (int n = 0; n < 3000; n++) begin
      if (m_halted && $urandom_range(0, 3) == 0) drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      else rand_cycle();
    end

    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard: %0d entries left, want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
